mc_control_unit: RTL and testbench

Control unit for the multicycle ARM-subset datapath. A main FSM sequences each instruction through fetch, decode, execute, memory and writeback. An instruction decoder produces the ALU and immediate controls. Condition logic holds the NZCV flags and gates every architectural write. It connects directly to the datapath control pins, plus MemWrite to the memory.

---
 rtl/mc_ctrl_pkg.sv | 40 ++++
 rtl/mc_control_unit_if.sv | 32 +++
 rtl/mc_cond_logic.sv | 70 +++++++
 rtl/mc_control_unit.sv | 170 +++++++++++++++++
 tb/tb_mc_control_unit.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle control unit.
package mc_ctrl_pkg;

  localparam int unsigned INSTR_W = 20;
  localparam int unsigned FLAGS_W = 4;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH, S_UNKNOWN
  } state_e;

  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_ORR = 2'b11} alu_ctrl_e;
  typedef enum logic [1:0] {SRCA_REG = 2'd0, SRCA_PC = 2'd1, SRCA_ALUOUT = 2'd2} srca_e;
  typedef enum logic [1:0] {SRCB_REG = 2'd0, SRCB_IMM = 2'd1, SRCB_FOUR = 2'd2} srcb_e;
  typedef enum logic [1:0] {RES_ALUOUT = 2'd0, RES_DATA = 2'd1, RES_ALURESULT = 2'd2} res_e;
  typedef enum logic [1:0] {OP_DP = 2'b00, OP_MEM = 2'b01, OP_BR = 2'b10, OP_UND = 2'b11} op_e;

  // Data-processing cmd field values that this subset implements.
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

endpackage

// File: rtl/mc_control_unit_if.sv
// Control-unit <-> datapath bundle.
//   master: control unit (receives Instr/ALUFlags, drives control pins)
//   slave : datapath / memory side
interface mc_control_unit_if;
  import mc_ctrl_pkg::*;

  logic [INSTR_W-1:0] Instr;
  logic [FLAGS_W-1:0] ALUFlags;
  logic       PCWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic       IRWrite;
  logic       AdrSrc;
  logic [1:0] RegSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ImmSrc;
  logic [1:0] ALUControl;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
  );
endinterface

// File: rtl/mc_cond_logic.sv
// NZCV flags register, condition evaluation and gating of architectural writes.
//   in : clk, rst_n, cond, alu_flags, flag_w {NZ,CV}, next_pc, branch, reg_w, mem_w, rd
//   out: pc_write, reg_write, mem_write (all forced low while rst_n = 0)
module mc_cond_logic
  import mc_ctrl_pkg::*;
#(
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       next_pc,
  input  logic       branch,
  input  logic       reg_w,
  input  logic       mem_w,
  input  logic [3:0] rd,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write
);

  logic [3:0] flags;
  logic       n, z, c, v;
  logic       cond_ex;
  logic       pcs;

  assign {n, z, c, v} = flags;

  // Flags register; NZ and CV halves are written independently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= FLAG_RESET;
    end else begin
      if (flag_w[1] && cond_ex) flags[3:2] <= alu_flags[3:2];
      if (flag_w[0] && cond_ex) flags[1:0] <= alu_flags[1:0];
    end
  end

  // Condition check against the stored flags.
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = !z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = !c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = !n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = !v;
      COND_HI: cond_ex = c && !z;
      COND_LS: cond_ex = !c || z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = !z && (n == v);
      COND_LE: cond_ex = z || (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // A register write to R15 is a PC write.
  assign pcs       = branch | (reg_w & (rd == 4'hF));
  assign pc_write  = rst_n & (next_pc | (pcs & cond_ex));
  assign reg_write = rst_n & reg_w & cond_ex;
  assign mem_write = rst_n & mem_w & cond_ex;

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle ARM-subset control unit: main FSM + instruction decoder,
// with flags/condition gating in mc_cond_logic.
//   clk, reset (async, active-low); bus: mc_control_unit_if.master
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter logic [3:0] FLAG_RESET   = 4'b0000,
  parameter bit         TRAP_ILLEGAL = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  mc_control_unit_if.master   bus
);

  state_e     state, state_d;
  op_e        op;
  logic [3:0] cond, rd, cmd;
  logic [5:0] funct;
  logic       unused_rn;

  logic       next_pc, ir_w, reg_w, mem_w, branch, in_exec, adr_src;
  srca_e      alu_src_a;
  srcb_e      alu_src_b;
  res_e       result_src;
  alu_ctrl_e  alu_ctrl, dec_alu;
  logic       cmd_legal, dp_illegal;
  logic [1:0] flag_w;
  logic       pc_write, reg_write, mem_write;

  assign cond      = bus.Instr[19:16];
  assign op        = op_e'(bus.Instr[15:14]);
  assign funct     = bus.Instr[13:8];
  assign rd        = bus.Instr[3:0];
  assign cmd       = funct[4:1];
  assign unused_rn = ^bus.Instr[7:4];

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_d;
  end

  // ALU operation decode for data-processing instructions.
  always_comb begin
    dec_alu   = ALU_ADD;
    cmd_legal = 1'b1;
    case (cmd)
      CMD_ADD: dec_alu = ALU_ADD;
      CMD_SUB: dec_alu = ALU_SUB;
      CMD_AND: dec_alu = ALU_AND;
      CMD_ORR: dec_alu = ALU_ORR;
      default: cmd_legal = 1'b0;
    endcase
  end

  assign dp_illegal = (op == OP_DP) && !cmd_legal;

  // Next-state and per-state control.
  always_comb begin
    state_d    = state;
    next_pc    = 1'b0;
    ir_w       = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    in_exec    = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = SRCA_REG;
    alu_src_b  = SRCB_REG;
    result_src = RES_ALUOUT;
    alu_ctrl   = ALU_ADD;
    case (state)
      S_FETCH: begin
        state_d    = S_DECODE;
        ir_w       = 1'b1;
        next_pc    = 1'b1;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        case (op)
          OP_DP:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_MEM:  state_d = S_MEMADR;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = TRAP_ILLEGAL ? S_UNKNOWN : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        state_d   = funct[0] ? S_MEMRD : S_MEMWR;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        state_d = S_MEMWB;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        state_d    = S_FETCH;
        result_src = RES_DATA;
        reg_w      = 1'b1;
      end
      S_MEMWR: begin
        state_d = S_FETCH;
        adr_src = 1'b1;
        mem_w   = 1'b1;
      end
      S_EXECUTER: begin
        state_d  = S_ALUWB;
        alu_ctrl = dec_alu;
        in_exec  = 1'b1;
      end
      S_EXECUTEI: begin
        state_d   = S_ALUWB;
        alu_src_b = SRCB_IMM;
        alu_ctrl  = dec_alu;
        in_exec   = 1'b1;
      end
      S_ALUWB: begin
        state_d = S_FETCH;
        reg_w   = !dp_illegal;
      end
      S_BRANCH: begin
        state_d    = S_FETCH;
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALURESULT;
        branch     = 1'b1;
      end
      S_UNKNOWN: state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  // Flag writes only for legal data-processing ops with S set, leaving EXECUTE.
  assign flag_w[1] = in_exec && (op == OP_DP) && cmd_legal && funct[0];
  assign flag_w[0] = flag_w[1] && ((cmd == CMD_ADD) || (cmd == CMD_SUB));

  mc_cond_logic #(
    .FLAG_RESET (FLAG_RESET)
  ) u_cond (
    .clk       (clk),
    .rst_n     (reset),
    .cond      (cond),
    .alu_flags (bus.ALUFlags),
    .flag_w    (flag_w),
    .next_pc   (next_pc),
    .branch    (branch),
    .reg_w     (reg_w),
    .mem_w     (mem_w),
    .rd        (rd),
    .pc_write  (pc_write),
    .reg_write (reg_write),
    .mem_write (mem_write)
  );

  assign bus.PCWrite    = pc_write;
  assign bus.RegWrite   = reg_write;
  assign bus.MemWrite   = mem_write;
  assign bus.IRWrite    = ir_w & reset;
  assign bus.AdrSrc     = adr_src;
  assign bus.RegSrc     = {op == OP_MEM, op == OP_BR};
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ResultSrc  = result_src;
  assign bus.ImmSrc     = op;
  assign bus.ALUControl = alu_ctrl;

endmodule

// File: tb/tb_mc_control_unit.sv
module tb_mc_control_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mc_control_unit_if bus ();
  mc_control_unit dut (.clk(clk), .reset(reset), .bus(bus));

  typedef enum int {PH_FETCH, PH_DECODE, PH_ADDR, PH_LOAD, PH_LOADWB, PH_STORE,
                    PH_EXEC_REG, PH_EXEC_IMM, PH_WB, PH_BRANCH, PH_TRAP} ph_t;
  typedef ph_t ph_q_t[$];

  typedef struct packed {
    logic       pcw, mw, rw, irw, adr;
    logic [1:0] regsrc, srca, srcb, res, imm, aluc;
  } obs_t;

  int errors = 0;
  int checks = 0;
  logic [3:0] mflags;

  // Behavioural model: ARM condition test.
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cc, v;
    n = f[3]; z = f[2]; cc = f[1]; v = f[0];
    case (c)
      4'h0: return z;          4'h1: return !z;
      4'h2: return cc;         4'h3: return !cc;
      4'h4: return n;          4'h5: return !n;
      4'h6: return v;          4'h7: return !v;
      4'h8: return cc && !z;   4'h9: return !cc || z;
      4'hA: return n == v;     4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Maps a cmd field to its ALU op code; negative result marks an illegal cmd.
  function automatic int alu_of(input logic [3:0] cmd);
    case (cmd)
      4'b0100: return 0;
      4'b0010: return 1;
      4'b0000: return 2;
      4'b1100: return 3;
      default: return -1;
    endcase
  endfunction

  // Cycle-by-cycle walk of one instruction.
  function automatic ph_q_t phases(input logic [31:0] ins);
    ph_q_t q;
    q.push_back(PH_FETCH);
    q.push_back(PH_DECODE);
    case (ins[27:26])
      2'b00: begin q.push_back(ins[25] ? PH_EXEC_IMM : PH_EXEC_REG); q.push_back(PH_WB); end
      2'b01: begin
        q.push_back(PH_ADDR);
        if (ins[20]) begin q.push_back(PH_LOAD); q.push_back(PH_LOADWB); end
        else q.push_back(PH_STORE);
      end
      2'b10: q.push_back(PH_BRANCH);
      default: q.push_back(PH_TRAP);
    endcase
    return q;
  endfunction

  function automatic obs_t expect_out(input ph_t ph, input logic [31:0] ins, input logic [3:0] fl);
    obs_t e;
    logic [1:0] op;
    int  a;
    bit  ok, bad_dp;
    op = ins[27:26];
    a  = alu_of(ins[24:21]);
    ok = cond_ok(ins[31:28], fl);
    bad_dp = (op == 2'b00) && (a < 0);
    e = '0;
    e.imm = op;
    e.regsrc = {op == 2'b01, op == 2'b10};
    case (ph)
      PH_FETCH:    begin e.irw = 1; e.pcw = 1; e.srca = 1; e.srcb = 2; e.res = 2; end
      PH_DECODE:   begin e.srca = 1; e.srcb = 2; e.res = 2; end
      PH_ADDR:     e.srcb = 1;
      PH_LOAD:     e.adr = 1;
      PH_LOADWB:   begin e.res = 1; e.rw = ok; e.pcw = ok && (ins[15:12] == 4'hF); end
      PH_STORE:    begin e.adr = 1; e.mw = ok; end
      PH_EXEC_REG: e.aluc = (a < 0) ? 2'd0 : 2'(a);
      PH_EXEC_IMM: begin e.srcb = 1; e.aluc = (a < 0) ? 2'd0 : 2'(a); end
      PH_WB:       begin e.rw = ok && !bad_dp; e.pcw = ok && !bad_dp && (ins[15:12] == 4'hF); end
      PH_BRANCH:   begin e.srcb = 1; e.res = 2; e.pcw = ok; end
      default:     ;
    endcase
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.pcw = bus.PCWrite;   o.mw = bus.MemWrite; o.rw = bus.RegWrite;
    o.irw = bus.IRWrite;   o.adr = bus.AdrSrc;  o.regsrc = bus.RegSrc;
    o.srca = bus.ALUSrcA;  o.srcb = bus.ALUSrcB; o.res = bus.ResultSrc;
    o.imm = bus.ImmSrc;    o.aluc = bus.ALUControl;
    return o;
  endfunction

  // Enter at a negedge with the DUT in FETCH; leave at a negedge in the next FETCH
  // (or mid-instruction after step stop_after when it is non-zero).
  task automatic run_instr(input logic [31:0] ins, input logic [3:0] exec_flags,
                           input string tag, input int stop_after);
    ph_q_t seq;
    obs_t got, exp;
    logic [3:0] af;
    int a;
    seq = phases(ins);
    a = alu_of(ins[24:21]);
    for (int i = 0; i < seq.size(); i++) begin
      if (i == 0) bus.Instr = ins[31:12];
      af = (seq[i] == PH_EXEC_REG || seq[i] == PH_EXEC_IMM) ? exec_flags : 4'($urandom);
      bus.ALUFlags = af;
      #1;
      got = sample();
      exp = expect_out(seq[i], ins, mflags);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s step %0d %s: got %h expected %h", tag, i, seq[i].name(), got, exp);
      end
      if (i + 1 == stop_after) return;
      @(posedge clk);
      if ((seq[i] == PH_EXEC_REG || seq[i] == PH_EXEC_IMM) && ins[27:26] == 2'b00 &&
          a >= 0 && ins[20] && cond_ok(ins[31:28], mflags)) begin
        mflags[3:2] = af[3:2];
        if (a <= 1) mflags[1:0] = af[1:0];
      end
      @(negedge clk);
    end
  endtask

  task automatic check_in_reset(input string tag);
    obs_t got, exp;
    exp = expect_out(PH_FETCH, {bus.Instr, 12'h0}, mflags);
    exp.pcw = 0; exp.irw = 0; exp.rw = 0; exp.mw = 0;
    got = sample();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic test_reset();
    bus.Instr = 20'h0;
    bus.ALUFlags = 4'h0;
    #1 reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1 check_in_reset("reset_hold");
    end
    @(negedge clk);
    reset = 1'b1;
    mflags = 4'b0000;
  endtask

  task automatic test_add();
    run_instr(32'hE0802001, 4'($urandom), "add_r2", 0);
  endtask

  task automatic test_subs_beq();
    run_instr(32'hE0533003, 4'b0110, "subs_z1", 0);
    run_instr(32'h0AFFFFFE, 4'($urandom), "beq_taken", 0);
  endtask

  task automatic test_beq_not_taken_ldr();
    run_instr(32'hE0533003, 4'b0000, "subs_z0", 0);
    run_instr(32'h0AFFFFFE, 4'($urandom), "beq_not_taken", 0);
    run_instr(32'hE5904008, 4'($urandom), "ldr", 0);
  endtask

  task automatic test_str();
    run_instr(32'hE5804008, 4'($urandom), "str", 0);
    run_instr(32'hE0533003, 4'b0100, "subs_setz", 0);
    run_instr(32'h15804008, 4'($urandom), "strne_fail", 0);
  endtask

  task automatic test_trap_and_pc_write();
    run_instr(32'hEC000000, 4'($urandom), "op11", 0);
    run_instr(32'hE08FF001, 4'($urandom), "add_pc", 0);
  endtask

  task automatic test_reset_mid();
    run_instr(32'hE5904008, 4'($urandom), "ldr_pre_reset", 4);
    reset = 1'b0;
    #1 check_in_reset("reset_in_memrd");
    @(posedge clk);
    #1 check_in_reset("reset_after_edge");
    @(negedge clk);
    reset = 1'b1;
    mflags = 4'b0000;
    run_instr(32'hE0802001, 4'($urandom), "add_after_reset", 0);
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [3:0]  c;
    for (int k = 0; k < 60; k++) begin
      c = ($urandom_range(0, 1) == 1) ? 4'hE : 4'($urandom);
      ins = {c, 2'($urandom), 6'($urandom), 4'($urandom), 4'($urandom), 12'($urandom)};
      if ($urandom_range(0, 3) == 0) ins[15:12] = 4'hF;
      run_instr(ins, 4'($urandom), $sformatf("rand%0d_%h", k, ins), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    mflags = 4'b0000;
    test_reset();
    test_add();
    test_subs_beq();
    test_beq_not_taken_ldr();
    test_str();
    test_trap_and_pc_write();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
